router_fsm_ctrl: RTL

//  Packet-sequencing controller for the 1x3 router. Decodes the header byte, then sequences

---
 rtl/router_fsm_ctrl_if.sv | 35 +++
 rtl/router_fsm_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/router_fsm_ctrl_if.sv
// rtl/router_fsm_ctrl_if.sv - handshake/status bundle between the router blocks and the packet controller
interface router_fsm_ctrl_if #(
    parameter int NUM_DEST = 3,
    parameter int ADDR_W   = 2
);
    logic                pkt_valid;
    logic [ADDR_W-1:0]   data_in;
    logic                fifo_full;
    logic [NUM_DEST-1:0] fifo_empty;
    logic [NUM_DEST-1:0] soft_reset;
    logic                parity_done;
    logic                low_pkt_valid;

    logic                busy;
    logic                detect_add;
    logic                lfd_state;
    logic                ld_state;
    logic                laf_state;
    logic                full_state;
    logic                write_enb_reg;
    logic                rst_int_reg;
    logic [ADDR_W-1:0]   dest_addr;

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, dest_addr
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
        output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, dest_addr
    );
endinterface

// File: rtl/router_fsm_ctrl.sv
// rtl/router_fsm_ctrl.sv - packet-sequencing controller for the 1x3 router
module router_fsm_ctrl #(
    parameter int NUM_DEST = 3,
    parameter int ADDR_W   = 2
) (
    input  logic             clock,
    input  logic             rst,
    router_fsm_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        LOAD_PARITY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        WAIT_TILL_EMPTY,
        CHECK_PARITY_ERROR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] dest_addr;
    logic              addr_ok;

    assign addr_ok = (int'(bus.data_in) < NUM_DEST);

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= DECODE_ADDRESS;
            dest_addr <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && bus.pkt_valid && addr_ok)
                dest_addr <= bus.data_in;
        end
    end

    // A destination timeout aborts any in-flight packet; in decode there is nothing to abort.
    always_comb begin
        next_state = state;
        if (state != DECODE_ADDRESS && bus.soft_reset[dest_addr]) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (bus.pkt_valid && addr_ok)
                        next_state = bus.fifo_empty[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       next_state = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!bus.fifo_full) next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        next_state = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) next_state = LOAD_PARITY;
                    else                        next_state = LOAD_DATA;
                end
                LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY: begin
                    if (bus.fifo_empty[dest_addr]) next_state = LOAD_FIRST_DATA;
                end
                default: next_state = DECODE_ADDRESS;
            endcase
        end
    end

    assign bus.detect_add    = (state == DECODE_ADDRESS);
    assign bus.lfd_state     = (state == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state == LOAD_DATA);
    assign bus.laf_state     = (state == LOAD_AFTER_FULL);
    assign bus.full_state    = (state == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    assign bus.busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
    assign bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                               (state == LOAD_AFTER_FULL);
    assign bus.dest_addr     = dest_addr;

endmodule
